// File: rtl/lifo_fifo_buf.sv
// Single storage array run as a stack (mode 0) or circular queue (mode 1); 1-cycle registered read,
// writes when full / reads when empty are ignored. Define LIFO_FIFO_ERR_FLAGS_EN for sticky overflow/underflow flags.
module lifo_fifo_buf #(
  parameter int DWIDTH       = 8,
  parameter int AWIDTH       = 4,
  parameter int ALMOST_FULL  = 15,
  parameter int ALMOST_EMPTY = 1
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic              mode_i,
  input  logic              wrreq_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              mode_o,
  output logic              empty_o,
  output logic              almost_empty_o,
  output logic              almost_full_o,
  output logic              full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int              DEPTH   = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_W    = (AWIDTH + 1)'(ALMOST_FULL);
  localparam logic [AWIDTH:0] AE_W    = (AWIDTH + 1)'(ALMOST_EMPTY);

  if (ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_bad_af
    $error("lifo_fifo_buf: ALMOST_FULL must lie in 1..DEPTH");
  end
  if (ALMOST_EMPTY < 0 || ALMOST_EMPTY > DEPTH - 1) begin : g_bad_ae
    $error("lifo_fifo_buf: ALMOST_EMPTY must lie in 0..DEPTH-1");
  end

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic [AWIDTH:0]   usedw_q, usedw_d;
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              mode_q, mode_d;
  logic              empty_q, empty_d, full_q, full_d;
  logic              aempty_q, aempty_d, afull_q, afull_d;
  logic              wr_acc, rd_acc;
  logic [AWIDTH-1:0] wr_addr, rd_addr, top_addr;

  always_comb begin
    wr_acc   = wrreq_i & ~full_q;
    rd_acc   = rdreq_i & ~empty_q;
    top_addr = usedw_q[AWIDTH-1:0] - AWIDTH'(1);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mode_d   = mode_q;

    if (mode_q) begin
      wr_addr = wr_ptr_q;
      rd_addr = rd_ptr_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + AWIDTH'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AWIDTH'(1);
    end else begin
      // A push that coincides with a pop replaces the top slot in place.
      rd_addr = top_addr;
      wr_addr = rd_acc ? top_addr : usedw_q[AWIDTH-1:0];
    end

    // No access can be accepted on a load cycle, so clearing the pointers is safe.
    if (empty_q && !wrreq_i) begin
      mode_d = mode_i;
      if (mode_i != mode_q) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
      end
    end

    rdata_d  = rd_acc ? mem_q[rd_addr] : rdata_q;
    usedw_d  = usedw_q + (AWIDTH + 1)'(wr_acc) - (AWIDTH + 1)'(rd_acc);
    empty_d  = (usedw_d == '0);
    full_d   = (usedw_d == DEPTH_W);
    aempty_d = (usedw_d <= AE_W);
    afull_d  = (usedw_d >= AF_W);
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      rdata_q  <= '0;
      usedw_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mode_q   <= 1'b0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      usedw_q  <= usedw_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mode_q   <= mode_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_n_i && wr_acc) mem_q[wr_addr] <= data_i;
  end

`ifdef LIFO_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (wrreq_i & full_q);
    underflow_d = underflow_q | (rdreq_i & empty_q);
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

  assign q_o            = rdata_q;
  assign mode_o         = mode_q;
  assign empty_o        = empty_q;
  assign almost_empty_o = aempty_q;
  assign almost_full_o  = afull_q;
  assign full_o         = full_q;
  assign usedw_o        = usedw_q;

endmodule

// File: tb/tb_lifo_fifo_buf.sv
// Bench for lifo_fifo_buf: directed plan, vector tables and random traffic against a queue model.
module tb_lifo_fifo_buf;
  localparam int DEPTH = 16;

  logic       clk_i = 1'b0;
  logic       srst_n_i, mode_i, wrreq_i, rdreq_i;
  logic [7:0] data_i;
  logic [7:0] q_o;
  logic       mode_o, empty_o, almost_empty_o, almost_full_o, full_o;
  logic [4:0] usedw_o;
  logic       overflow_o, underflow_o;

  always #5 clk_i = ~clk_i;

  lifo_fifo_buf #(.DWIDTH(8), .AWIDTH(4), .ALMOST_FULL(15), .ALMOST_EMPTY(1)) dut (
    .clk_i(clk_i), .srst_n_i(srst_n_i), .mode_i(mode_i), .wrreq_i(wrreq_i),
    .data_i(data_i), .rdreq_i(rdreq_i), .q_o(q_o), .mode_o(mode_o),
    .empty_o(empty_o), .almost_empty_o(almost_empty_o), .almost_full_o(almost_full_o),
    .full_o(full_o), .usedw_o(usedw_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: stored words oldest-first; a stack pops from the back, a queue from the front.
  logic [7:0] mq[$];
  logic [7:0] m_q;
  logic       m_mode, m_ovf, m_unf;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] d;
    logic [7:0] exp_q;
    logic [4:0] exp_used;
  } vec_t;

  vec_t t1[7];
  vec_t t2[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_model();
    chk("q", q_o, m_q);
    chk("usedw", usedw_o, mq.size());
    chk("empty", empty_o, mq.size() == 0);
    chk("full", full_o, mq.size() == DEPTH);
    chk("almost_full", almost_full_o, mq.size() >= 15);
    chk("almost_empty", almost_empty_o, mq.size() <= 1);
    chk("mode", mode_o, m_mode);
    chk("overflow", overflow_o, m_ovf);
    chk("underflow", underflow_o, m_unf);
  endtask

  task automatic do_reset();
    srst_n_i = 1'b0; wrreq_i = 1'b0; rdreq_i = 1'b0; mode_i = 1'b0; data_i = '0;
    @(posedge clk_i); #1;
    srst_n_i = 1'b1;
    mq.delete();
    m_q = '0; m_mode = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic step(input logic wr, input logic rd, input logic md, input logic [7:0] d);
    bit was_full, was_empty, wa, ra;
    wrreq_i = wr; rdreq_i = rd; mode_i = md; data_i = d;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    wa = wr && !was_full;
    ra = rd && !was_empty;
`ifdef LIFO_FIFO_ERR_FLAGS_EN
    if (wr && was_full) m_ovf = 1'b1;
    if (rd && was_empty) m_unf = 1'b1;
`endif
    if (ra) m_q = m_mode ? mq.pop_front() : mq.pop_back();
    if (wa) mq.push_back(d);
    if (was_empty && !wr) m_mode = md;
    @(posedge clk_i); #1;
    chk_model();
  endtask

  task automatic run_vec(input vec_t v);
    step(v.wr, v.rd, 1'b0, v.d);
    chk("tbl_q", q_o, v.exp_q);
    chk("tbl_usedw", usedw_o, v.exp_used);
  endtask

  initial begin
    int bias;
    logic md;
    t1[0] = '{1'b1, 1'b1, 8'h55, 8'h0F, 5'd15};
    t1[1] = '{1'b0, 1'b1, 8'h00, 8'h55, 5'd14};
    t1[2] = '{1'b1, 1'b0, 8'h66, 8'h55, 5'd15};
    t1[3] = '{1'b1, 1'b0, 8'h77, 8'h55, 5'd16};
    t1[4] = '{1'b1, 1'b0, 8'h88, 8'h55, 5'd16};
    t1[5] = '{1'b1, 1'b1, 8'h99, 8'h77, 5'd15};
    t1[6] = '{1'b0, 1'b1, 8'h00, 8'h66, 5'd14};
    t2[0] = '{1'b1, 1'b1, 8'hC3, 8'h01, 5'd1};
    t2[1] = '{1'b0, 1'b1, 8'h00, 8'hC3, 5'd0};
    t2[2] = '{1'b0, 1'b1, 8'h00, 8'hC3, 5'd0};

    do_reset();
    chk("rst_q", q_o, 0);
    chk("rst_usedw", usedw_o, 0);
    chk("rst_mode", mode_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_aempty", almost_empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_afull", almost_full_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_unf", underflow_o, 0);

    // LIFO fill and drain
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'(i + 1));
    chk("lifo_full", full_o, 1);
    chk("lifo_used16", usedw_o, 16);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("lifo_pop", q_o, 8'h10 - i);
    end
    chk("lifo_empty", empty_o, 1);
    chk("lifo_used0", usedw_o, 0);

    // FIFO with pointer wrap
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("fifo_mode", mode_o, 1);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 8'hA0 + 8'(i));
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'h00);
      chk("fifo_pop_a", q_o, 8'hA0 + i);
    end
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 8'hB0 + 8'(i));
    chk("fifo_full", full_o, 1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'h00);
      chk("fifo_pop_wrap", q_o, (i < 8) ? 8'hA8 + i : 8'hB0 + i - 8);
    end

    // Back to LIFO, fill to 15 watching almost_full
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("lifo_mode", mode_o, 0);
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(i + 1));
      if (i == 13) chk("afull_at14", almost_full_o, 0);
      if (i == 14) chk("afull_at15", almost_full_o, 1);
    end
    for (int i = 0; i < 7; i++) run_vec(t1[i]);

    // Drain 14 words watching almost_empty
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("drain_q", q_o, 8'h0E - i);
      if (i == 11) chk("aempty_at2", almost_empty_o, 0);
      if (i == 12) chk("aempty_at1", almost_empty_o, 1);
    end
    for (int i = 0; i < 3; i++) run_vec(t2[i]);
`ifdef LIFO_FIFO_ERR_FLAGS_EN
    chk("underflow_set", underflow_o, 1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("underflow_sticky", underflow_o, 1);
`else
    chk("underflow_tied", underflow_o, 0);
`endif
    do_reset();
    chk("underflow_rst", underflow_o, 0);

    // Pending mode request waits for an empty, write-free cycle
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h30 + 8'(i));
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("mode_hold3", mode_o, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'h00);
      chk("mode_hold_rd", mode_o, 0);
    end
    chk("mode_drained", usedw_o, 0);
    step(1'b1, 1'b0, 1'b1, 8'h5A);
    chk("mode_hold_wr", mode_o, 0);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    chk("mode_lifo_pop", q_o, 8'h5A);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("mode_loaded", mode_o, 1);

    // Random traffic with phased fill/drain bias and a mid-run reset
    bias = 50;
    md = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) bias = $urandom_range(15, 85);
      if ($urandom_range(0, 39) == 0) md = ~md;
      if (n == 1500) begin
        do_reset();
        chk_model();
      end
      step(($urandom_range(0, 99) < bias), ($urandom_range(0, 99) >= bias),
           md, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
